// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding and progc select codes.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        VALID,
        SQUASH
    } fetch_state_t;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_ABS = 2'b01;

endpackage

// File: rtl/fetch_buf.sv
// One-entry instruction buffer holding a fetched word and its PC while decode stalls.
module fetch_buf #(
    parameter int unsigned PCLEN = 32,
    parameter int unsigned ILEN  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [ILEN-1:0]  load_instr,
    input  logic [PCLEN-1:0] load_pc,
    output logic [ILEN-1:0]  instr,
    output logic [PCLEN-1:0] pc
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            instr <= '0;
            pc    <= '0;
        end else if (load) begin
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues imem requests at the current PC, steers progc, buffers one
// instruction for decode back-pressure and squashes in-flight fetches on execute redirects.
module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned PCLEN = 32,
    parameter int unsigned ILEN  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [PCLEN-1:0] pc_in,
    output logic             pc_en,
    output logic [1:0]       pcsel,
    output logic [PCLEN-1:0] targaddr,
    output logic             imem_req,
    output logic [PCLEN-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [ILEN-1:0]  imem_rdata,
    output logic             if_valid,
    output logic [ILEN-1:0]  if_instr,
    output logic [PCLEN-1:0] if_pc,
    input  logic             id_ready,
    input  logic             ex_redirect,
    input  logic [PCLEN-1:0] ex_target,
    output logic             flush
);

    fetch_state_t     state;
    logic [PCLEN-1:0] pend_target;

    logic             buf_load;
    logic             buf_clear;
    logic [ILEN-1:0]  buf_instr;
    logic [PCLEN-1:0] buf_pc;

    fetch_buf #(
        .PCLEN (PCLEN),
        .ILEN  (ILEN)
    ) u_fetch_buf (
        .clock      (clock),
        .reset      (reset),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_instr (imem_rdata),
        .load_pc    (pc_in),
        .instr      (buf_instr),
        .pc         (buf_pc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pend_target <= '0;
        end else begin
            unique case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (ex_redirect && !imem_ack) begin
                        // Request cannot be withdrawn; remember where to go once it drains.
                        pend_target <= ex_target;
                        state       <= SQUASH;
                    end else if (imem_ack && !ex_redirect && !id_ready) begin
                        state <= VALID;
                    end
                end
                VALID: begin
                    if (ex_redirect || id_ready) begin
                        state <= REQ;
                    end
                end
                SQUASH: begin
                    if (imem_ack) begin
                        state <= REQ;
                    end else if (ex_redirect) begin
                        pend_target <= ex_target;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        pc_en     = 1'b0;
        pcsel     = PCSEL_SEQ;
        targaddr  = '0;
        imem_req  = 1'b0;
        imem_addr = '0;
        if_valid  = 1'b0;
        if_instr  = '0;
        if_pc     = '0;
        flush     = 1'b0;
        buf_load  = 1'b0;
        buf_clear = 1'b0;

        unique case (state)
            IDLE: ;
            REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc_in;
                if (ex_redirect) begin
                    flush = 1'b1;
                    if (imem_ack) begin
                        pc_en    = 1'b1;
                        pcsel    = PCSEL_ABS;
                        targaddr = ex_target;
                    end
                end else if (imem_ack) begin
                    pc_en = 1'b1;
                    if (id_ready) begin
                        if_valid = 1'b1;
                        if_instr = imem_rdata;
                        if_pc    = pc_in;
                    end else begin
                        buf_load = 1'b1;
                    end
                end
            end
            VALID: begin
                if (ex_redirect) begin
                    buf_clear = 1'b1;
                    pc_en     = 1'b1;
                    pcsel     = PCSEL_ABS;
                    targaddr  = ex_target;
                    flush     = 1'b1;
                end else begin
                    if_valid = 1'b1;
                    if_instr = buf_instr;
                    if_pc    = buf_pc;
                end
            end
            SQUASH: begin
                imem_req  = 1'b1;
                imem_addr = pc_in;
                flush     = ex_redirect;
                if (imem_ack) begin
                    pc_en    = 1'b1;
                    pcsel    = PCSEL_ABS;
                    // A redirect arriving with the ack is newer than the pending one.
                    targaddr = ex_redirect ? ex_target : pend_target;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with a progc model, a latency-controlled imem model
// and a scoreboard of instructions expected at the decode handshake.
module tb_fetch_ctrl;

    logic        clock;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_en;
    logic [1:0]  pcsel;
    logic [31:0] targaddr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        flush;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_bad;
    int   mem_lat;
    int   wait_cnt;

    fetch_ctrl #(
        .PCLEN (32),
        .ILEN  (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_en       (pc_en),
        .pcsel       (pcsel),
        .targaddr    (targaddr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .flush       (flush)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // progc model
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pc_in <= '0;
        else if (pc_en) pc_in <= (pcsel == 2'b01) ? targaddr : pc_in + 32'd1;
    end

    // imem model: acks once a request has waited mem_lat cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) wait_cnt <= 0;
        else wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
    end
    assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
    assign imem_rdata = instr_of(imem_addr);

    task automatic sb_check();
        exp_t e;
        if (if_valid && id_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got pc %h instr %h, want no delivery", if_pc, if_instr);
            end else begin
                e = sb_q.pop_front();
                if (if_pc !== e.pc || if_instr !== e.instr) begin
                    n_bad++;
                    $display("FAIL sb_deliver: got pc %h instr %h, want pc %h instr %h",
                             if_pc, if_instr, e.pc, e.instr);
                end
            end
        end
    endtask

    task automatic end_cycle();
        sb_check();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", if_valid); end
        n_cmp++; if ({pc_en, pcsel, flush} !== 4'b0) begin n_bad++; $display("FAIL rst_ctl: got %b want 0", {pc_en, pcsel, flush}); end
        n_cmp++; if (targaddr !== 32'd0 || imem_addr !== 32'd0) begin n_bad++; $display("FAIL rst_addr: got %h/%h want 0/0", targaddr, imem_addr); end
        reset = 1'b1;
        #4;
        n_cmp++; if (imem_req !== 1'b0 || pc_en !== 1'b0) begin n_bad++; $display("FAIL idle_cycle: got req %b pc_en %b want 0 0", imem_req, pc_en); end
        end_cycle();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) sb_q.push_back('{pc: 32'(i), instr: instr_of(32'(i))});
        for (int i = 0; i < 4; i++) begin
            #4;
            n_cmp++; if (if_pc !== 32'(i) || if_valid !== 1'b1) begin n_bad++; $display("FAIL seq_pc%0d: got %h v%b want %h v1", i, if_pc, if_valid, i); end
            n_cmp++; if (pc_en !== 1'b1 || pcsel !== 2'b00) begin n_bad++; $display("FAIL seq_pcen%0d: got %b/%b want 1/00", i, pc_en, pcsel); end
            end_cycle();
        end
    endtask

    task automatic test_stall();
        sb_q.push_back('{pc: 32'd4, instr: instr_of(32'd4)});
        #4; end_cycle();
        id_ready = 1'b0;
        #4;
        n_cmp++; if (if_valid !== 1'b0 || pc_en !== 1'b1 || imem_addr !== 32'd5) begin n_bad++; $display("FAIL stall_load: got v%b en%b addr %h want v0 en1 addr 5", if_valid, pc_en, imem_addr); end
        end_cycle();
        for (int i = 0; i < 3; i++) begin
            #4;
            n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd5 || if_instr !== instr_of(32'd5)) begin n_bad++; $display("FAIL stall_hold%0d: got v%b pc %h instr %h want v1 pc 5 instr %h", i, if_valid, if_pc, if_instr, instr_of(32'd5)); end
            n_cmp++; if (imem_req !== 1'b0 || pc_en !== 1'b0) begin n_bad++; $display("FAIL stall_quiet%0d: got req %b en %b want 0 0", i, imem_req, pc_en); end
            end_cycle();
        end
        sb_q.push_back('{pc: 32'd5, instr: instr_of(32'd5)});
        id_ready = 1'b1;
        #4; end_cycle();
        sb_q.push_back('{pc: 32'd6, instr: instr_of(32'd6)});
        #4;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'd6) begin n_bad++; $display("FAIL stall_next: got req %b addr %h want 1 6", imem_req, imem_addr); end
        end_cycle();
    endtask

    task automatic test_redirect_wait();
        mem_lat = 3;
        #4;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'd7 || flush !== 1'b0) begin n_bad++; $display("FAIL rw_wait: got req %b addr %h fl %b want 1 7 0", imem_req, imem_addr, flush); end
        end_cycle();
        ex_redirect = 1'b1; ex_target = 32'h40;
        #4;
        n_cmp++; if (flush !== 1'b1 || pc_en !== 1'b0 || imem_addr !== 32'd7) begin n_bad++; $display("FAIL rw_flush: got fl %b en %b addr %h want 1 0 7", flush, pc_en, imem_addr); end
        end_cycle();
        ex_redirect = 1'b0;
        #4;
        n_cmp++; if (flush !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd7) begin n_bad++; $display("FAIL rw_squash: got fl %b req %b addr %h want 0 1 7", flush, imem_req, imem_addr); end
        end_cycle();
        #4;
        n_cmp++; if (if_valid !== 1'b0 || pc_en !== 1'b1 || pcsel !== 2'b01 || targaddr !== 32'h40) begin n_bad++; $display("FAIL rw_ack: got v%b en%b sel %b tgt %h want v0 en1 sel 01 tgt 40", if_valid, pc_en, pcsel, targaddr); end
        end_cycle();
        #4;
        n_cmp++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin n_bad++; $display("FAIL rw_next: got addr %h req %b want 40 1", imem_addr, imem_req); end
        end_cycle();
    endtask

    task automatic test_double_redirect();
        mem_lat = 4;
        ex_redirect = 1'b1; ex_target = 32'h40;
        #4;
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL dr_flush1: got %b want 1", flush); end
        end_cycle();
        ex_redirect = 1'b0;
        #4;
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL dr_gap: got %b want 0", flush); end
        end_cycle();
        ex_redirect = 1'b1; ex_target = 32'h80;
        #4;
        n_cmp++; if (flush !== 1'b1 || pc_en !== 1'b0) begin n_bad++; $display("FAIL dr_flush2: got fl %b en %b want 1 0", flush, pc_en); end
        end_cycle();
        ex_redirect = 1'b0;
        #4;
        n_cmp++; if (pc_en !== 1'b1 || pcsel !== 2'b01 || targaddr !== 32'h80 || flush !== 1'b0) begin n_bad++; $display("FAIL dr_ack: got en%b sel %b tgt %h fl %b want en1 sel 01 tgt 80 fl 0", pc_en, pcsel, targaddr, flush); end
        end_cycle();
    endtask

    task automatic test_valid_redirect();
        mem_lat = 0; id_ready = 1'b0;
        #4;
        n_cmp++; if (imem_addr !== 32'h80 || pc_en !== 1'b1 || if_valid !== 1'b0) begin n_bad++; $display("FAIL vr_load: got addr %h en %b v %b want 80 1 0", imem_addr, pc_en, if_valid); end
        end_cycle();
        id_ready = 1'b1; ex_redirect = 1'b1; ex_target = 32'h20;
        #4;
        n_cmp++; if (if_valid !== 1'b0 || flush !== 1'b1 || imem_req !== 1'b0) begin n_bad++; $display("FAIL vr_drop: got v%b fl%b req%b want 0 1 0", if_valid, flush, imem_req); end
        n_cmp++; if (pc_en !== 1'b1 || pcsel !== 2'b01 || targaddr !== 32'h20) begin n_bad++; $display("FAIL vr_sel: got en%b sel %b tgt %h want 1 01 20", pc_en, pcsel, targaddr); end
        end_cycle();
        ex_redirect = 1'b0; id_ready = 1'b0; mem_lat = 8;
        #4;
        n_cmp++; if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin n_bad++; $display("FAIL vr_next: got addr %h req %b want 20 1", imem_addr, imem_req); end
        end_cycle();
    endtask

    task automatic test_async_reset();
        ex_redirect = 1'b1; ex_target = 32'h99;
        #4;
        n_cmp++; if (flush !== 1'b1 || imem_req !== 1'b1) begin n_bad++; $display("FAIL ar_pre: got fl %b req %b want 1 1", flush, imem_req); end
        #1 reset = 1'b0;
        #1;
        n_cmp++; if ({imem_req, if_valid, flush, pc_en} !== 4'b0000) begin n_bad++; $display("FAIL ar_async: got %b want 0000", {imem_req, if_valid, flush, pc_en}); end
        ex_redirect = 1'b0; mem_lat = 0; id_ready = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1;
        #4;
        n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_bad++; $display("FAIL ar_idle: got req %b v %b want 0 0", imem_req, if_valid); end
        end_cycle();
        sb_q.push_back('{pc: 32'd0, instr: instr_of(32'd0)});
        #4;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin n_bad++; $display("FAIL ar_req: got req %b addr %h want 1 0", imem_req, imem_addr); end
        end_cycle();
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size()); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b0; id_ready = 1'b1; ex_redirect = 1'b0; ex_target = '0; mem_lat = 0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_double_redirect();
        test_valid_redirect();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
